// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: ALU op codes, PC source select,
// opcode/funct constants, FSM state codes and the decoded instruction class.
package multicycle_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADDU = 2'b00;
    localparam logic [1:0] ALUOP_SUBU = 2'b01;
    localparam logic [1:0] ALUOP_ORI  = 2'b10;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    typedef enum logic [2:0] {
        CLS_ADDU,
        CLS_SUBU,
        CLS_ORI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_BAD
    } instr_cls_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller (master) and the datapath/memory side (slave).
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             Zero;
    logic             mem_ready;
    logic [1:0]       ALUOp;
    logic             alu_src_imm;
    logic             reg_dst_rd;
    logic             mem_to_reg;
    logic [1:0]       pc_src;
    logic             pc_we;
    logic             ir_we;
    logic             reg_we;
    logic             mem_re;
    logic             mem_we;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, Zero, mem_ready,
        output ALUOp, alu_src_imm, reg_dst_rd, mem_to_reg, pc_src,
               pc_we, ir_we, reg_we, mem_re, mem_we, illegal, timeout, retired
    );

    modport slave (
        output opcode, funct, Zero, mem_ready,
        input  ALUOp, alu_src_imm, reg_dst_rd, mem_to_reg, pc_src,
               pc_we, ir_we, reg_we, mem_re, mem_we, illegal, timeout, retired
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class and legal flag.
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output instr_cls_e cls_o,
    output logic       legal_o
);

    always_comb begin
        cls_o = CLS_BAD;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i == FN_ADDU)      cls_o = CLS_ADDU;
                else if (funct_i == FN_SUBU) cls_o = CLS_SUBU;
            end
            OP_ORI:  cls_o = CLS_ORI;
            OP_LW:   cls_o = CLS_LW;
            OP_SW:   cls_o = CLS_SW;
            OP_BEQ:  cls_o = CLS_BEQ;
            OP_J:    cls_o = CLS_J;
            default: cls_o = CLS_BAD;
        endcase
        legal_o = (cls_o != CLS_BAD);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory wait watchdog
// and a wrapping retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    logic [2:0]       state_q, state_d;
    instr_cls_e       cls_q, cls_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    instr_cls_e dec_cls;
    logic       dec_legal;
    logic       retire;

    logic [1:0] aluop, pc_src;
    logic       alu_src_imm, reg_dst_rd, mem_to_reg;
    logic       pc_we, ir_we, reg_we, mem_re, mem_we;

    mc_decode u_decode (
        .opcode_i (bus.opcode),
        .funct_i  (bus.funct),
        .cls_o    (dec_cls),
        .legal_o  (dec_legal)
    );

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        wait_d      = wait_q;
        retired_d   = retired_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        retire      = 1'b0;
        aluop       = ALUOP_ADDU;
        alu_src_imm = 1'b0;
        reg_dst_rd  = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = PC_SRC_PC4;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_re = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            // DECODE acts on the live memory word; later states use the latched class.
            S_DECODE: begin
                cls_d = dec_cls;
                if (!dec_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else if (dec_cls == CLS_J) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_SRC_JUMP;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_SUBU: aluop = ALUOP_SUBU;
                    CLS_ORI: begin
                        aluop       = ALUOP_ORI;
                        alu_src_imm = 1'b1;
                    end
                    CLS_LW, CLS_SW: alu_src_imm = 1'b1;
                    CLS_BEQ: begin
                        aluop  = ALUOP_SUBU;
                        pc_src = PC_SRC_BRANCH;
                        pc_we  = bus.Zero;
                    end
                    default: aluop = ALUOP_ADDU;
                endcase
                if (cls_q == CLS_BEQ) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (cls_q == CLS_LW || cls_q == CLS_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_src_imm = 1'b1;
                mem_re      = (cls_q == CLS_LW);
                mem_we      = (cls_q == CLS_SW);
                if (bus.mem_ready) begin
                    if (cls_q == CLS_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst_rd = (cls_q == CLS_ADDU) || (cls_q == CLS_SUBU);
                mem_to_reg = (cls_q == CLS_LW);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase

        // Any state change is an entry into a fresh wait window.
        if (state_d != state_q) wait_d = '0;
        if (retire) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= CLS_BAD;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobes are masked by rst_n so an asserted reset silences them without waiting for a clock.
    assign bus.pc_we       = pc_we  & rst_n;
    assign bus.ir_we       = ir_we  & rst_n;
    assign bus.reg_we      = reg_we & rst_n;
    assign bus.mem_re      = mem_re & rst_n;
    assign bus.mem_we      = mem_we & rst_n;
    assign bus.ALUOp       = aluop;
    assign bus.alu_src_imm = alu_src_imm;
    assign bus.reg_dst_rd  = reg_dst_rd;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.pc_src      = pc_src;
    assign bus.illegal     = illegal_q;
    assign bus.timeout     = timeout_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(4)) bus ();

    multicycle_ctrl #(.WAIT_MAX(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       nm;
        logic [17:0] v;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {ALUOp, src_imm, reg_dst_rd, mem_to_reg, pc_src, pc_we, ir_we, reg_we, mem_re, mem_we, illegal, timeout, retired}
    wire [17:0] act = {bus.ALUOp, bus.alu_src_imm, bus.reg_dst_rd, bus.mem_to_reg, bus.pc_src,
                       bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_re, bus.mem_we,
                       bus.illegal, bus.timeout, bus.retired};

    function automatic logic [17:0] ev(input logic [1:0] alu, input logic src, input logic rd,
                                       input logic m2r, input logic [1:0] pcs, input logic pcw,
                                       input logic irw, input logic rgw, input logic mre,
                                       input logic mwe, input logic ill, input logic tmo,
                                       input logic [3:0] ret);
        return {alu, src, rd, m2r, pcs, pcw, irw, rgw, mre, mwe, ill, tmo, ret};
    endfunction

    function automatic logic [17:0] v_fetch(input logic [3:0] ret);
        return ev(2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 1, 0, 0, 0, ret);
    endfunction

    function automatic logic [17:0] v_idle(input logic [3:0] ret);
        return ev(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, ret);
    endfunction

    function automatic logic [17:0] v_jump(input logic [3:0] ret);
        return ev(2'b00, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, ret);
    endfunction

    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            exp_t x;
            x = sbq.pop_front();
            n_cmp++;
            if (act !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %b required %b", x.nm, act, x.v);
            end
        end
    end

    task automatic cyc(input string nm, input logic rn, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [17:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n         = rn;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.Zero      = z;
        bus.mem_ready = rdy;
        x.nm = nm;
        x.v  = e;
        sbq.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 6'd0;
        bus.funct     = 6'd0;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;

        cyc("reset0", 0, 6'h00, 6'h00, 0, 1, v_idle(0));
        cyc("reset1", 0, 6'h00, 6'h00, 0, 1, v_idle(0));

        // addu
        cyc("addu_fetch", 1, 6'h00, 6'h21, 0, 1, v_fetch(0));
        cyc("addu_dec",   1, 6'h00, 6'h21, 0, 1, v_idle(0));
        cyc("addu_exec",  1, 6'h00, 6'h21, 0, 1, v_idle(0));
        cyc("addu_wb",    1, 6'h00, 6'h21, 0, 1, ev(2'b00, 0, 1, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));

        // lw with three wait cycles in MEM
        cyc("lw_fetch", 1, 6'h23, 6'h00, 0, 1, v_fetch(1));
        cyc("lw_dec",   1, 6'h23, 6'h00, 0, 1, v_idle(1));
        cyc("lw_exec",  1, 6'h23, 6'h00, 0, 1, ev(2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            cyc("lw_mem_wait", 1, 6'h23, 6'h00, 0, 0, ev(2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 1));
        cyc("lw_mem_done", 1, 6'h23, 6'h00, 0, 1, ev(2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 1));
        cyc("lw_wb",       1, 6'h23, 6'h00, 0, 1, ev(2'b00, 0, 0, 1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 1));

        // beq taken / not taken
        cyc("beq1_fetch", 1, 6'h04, 6'h00, 1, 1, v_fetch(2));
        cyc("beq1_dec",   1, 6'h04, 6'h00, 1, 1, v_idle(2));
        cyc("beq1_exec",  1, 6'h04, 6'h00, 1, 1, ev(2'b01, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 2));
        cyc("beq0_fetch", 1, 6'h04, 6'h00, 0, 1, v_fetch(3));
        cyc("beq0_dec",   1, 6'h04, 6'h00, 0, 1, v_idle(3));
        cyc("beq0_exec",  1, 6'h04, 6'h00, 0, 1, ev(2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 3));

        // j
        cyc("j_fetch", 1, 6'h02, 6'h00, 0, 1, v_fetch(4));
        cyc("j_dec",   1, 6'h02, 6'h00, 0, 1, v_jump(4));

        // ori
        cyc("ori_fetch", 1, 6'h0D, 6'h00, 0, 1, v_fetch(5));
        cyc("ori_dec",   1, 6'h0D, 6'h00, 0, 1, v_idle(5));
        cyc("ori_exec",  1, 6'h0D, 6'h00, 0, 1, ev(2'b10, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5));
        cyc("ori_wb",    1, 6'h0D, 6'h00, 0, 1, ev(2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 5));

        // subu
        cyc("subu_fetch", 1, 6'h00, 6'h23, 0, 1, v_fetch(6));
        cyc("subu_dec",   1, 6'h00, 6'h23, 0, 1, v_idle(6));
        cyc("subu_exec",  1, 6'h00, 6'h23, 0, 1, ev(2'b01, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6));
        cyc("subu_wb",    1, 6'h00, 6'h23, 0, 1, ev(2'b00, 0, 1, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 6));

        // sw
        cyc("sw_fetch", 1, 6'h2B, 6'h00, 0, 1, v_fetch(7));
        cyc("sw_dec",   1, 6'h2B, 6'h00, 0, 1, v_idle(7));
        cyc("sw_exec",  1, 6'h2B, 6'h00, 0, 1, ev(2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7));
        cyc("sw_mem",   1, 6'h2B, 6'h00, 0, 1, ev(2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 7));

        // illegal opcode -> absorbing TRAP
        cyc("ill_fetch", 1, 6'h3F, 6'h00, 0, 1, v_fetch(8));
        cyc("ill_dec",   1, 6'h3F, 6'h00, 0, 1, v_idle(8));
        for (int i = 0; i < 10; i++)
            cyc("ill_trap", 1, 6'h3F, 6'h00, 1, 1, ev(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 8));

        // illegal R-type funct
        cyc("rst_a", 0, 6'h00, 6'h00, 0, 1, v_idle(0));
        cyc("illfn_fetch", 1, 6'h00, 6'h00, 0, 1, v_fetch(0));
        cyc("illfn_dec",   1, 6'h00, 6'h00, 0, 1, v_idle(0));
        cyc("illfn_trap",  1, 6'h00, 6'h00, 0, 1, ev(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0));

        // FETCH timeout after WAIT_MAX=4 idle cycles
        cyc("rst_b", 0, 6'h00, 6'h00, 0, 0, v_idle(0));
        for (int i = 0; i < 4; i++)
            cyc("to_fetch_wait", 1, 6'h02, 6'h00, 0, 0, ev(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc("to_trap", 1, 6'h02, 6'h00, 0, 1, ev(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));

        // mem_ready on the last allowed wait cycle wins over timeout
        cyc("rst_c", 0, 6'h02, 6'h00, 0, 0, v_idle(0));
        for (int i = 0; i < 3; i++)
            cyc("rw_fetch_wait", 1, 6'h02, 6'h00, 0, 0, ev(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc("rw_fetch_done", 1, 6'h02, 6'h00, 0, 1, v_fetch(0));
        cyc("rw_dec",        1, 6'h02, 6'h00, 0, 1, v_jump(0));

        // reset while sw is in MEM
        cyc("msw_fetch", 1, 6'h2B, 6'h00, 0, 1, v_fetch(1));
        cyc("msw_dec",   1, 6'h2B, 6'h00, 0, 1, v_idle(1));
        cyc("msw_exec",  1, 6'h2B, 6'h00, 0, 1, ev(2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc("msw_mem",   1, 6'h2B, 6'h00, 0, 0, ev(2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1));
        cyc("msw_rst0",  0, 6'h2B, 6'h00, 0, 1, v_idle(0));
        cyc("msw_rst1",  0, 6'h2B, 6'h00, 0, 1, v_idle(0));
        cyc("msw_refetch", 1, 6'h02, 6'h00, 0, 1, v_fetch(0));

        // 16 jumps wrap the 4-bit retired counter
        cyc("wrap_dec0", 1, 6'h02, 6'h00, 0, 1, v_jump(0));
        for (int i = 1; i < 16; i++) begin
            cyc("wrap_fetch", 1, 6'h02, 6'h00, 0, 1, v_fetch(4'(i)));
            cyc("wrap_dec",   1, 6'h02, 6'h00, 0, 1, v_jump(4'(i)));
        end
        cyc("wrap_zero", 1, 6'h02, 6'h00, 0, 1, v_fetch(0));

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
